// File: rtl/pc_next_unit.sv
// Purpose : program-counter sequencer with branch/jump/jr selection and a one-cycle misaligned-jr trap.
// Latency : single cycle; controls sampled at edge N set pc after edge N (pc_plus4/branch_taken are combinational).
// Backpressure: en=0 is a full stall; pc, state, epc, exc and retire_cnt all hold.
module pc_next_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             branch,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic             jump,
    input  logic             jr,
    input  logic [WIDTH-1:0] offset_sl2,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] reg_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             branch_taken,
    output logic             exc,
    output logic [WIDTH-1:0] epc,
    output logic [31:0]      retire_cnt
);

    // RUN: normal sequencing. TRAP: the one cycle spent at the exception vector.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             exc_q, exc_d;
    logic [31:0]      retire_cnt_q, retire_cnt_d;

    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             jr_misaligned;

    // Target arithmetic; all sums wrap modulo 2^WIDTH by construction.
    always_comb begin
        pc_plus4      = pc_q + WIDTH'(4);
        branch_target = pc_plus4 + offset_sl2;
        jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
        branch_taken  = branch & (zero ^ branch_ne);
        jr_misaligned = |reg_target[1:0];
    end

    // Next-state and next-PC selection; jr outranks jump, which outranks a taken branch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        exc_d        = exc_q;
        retire_cnt_d = retire_cnt_q;

        if (en) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
            case (state_q)
                ST_RUN: begin
                    if (jr) begin
                        if (jr_misaligned) begin
                            pc_d    = EXC_VECTOR;
                            epc_d   = pc_q;
                            exc_d   = 1'b1;
                            state_d = ST_TRAP;
                        end else begin
                            pc_d = reg_target;
                        end
                    end else if (jump) begin
                        pc_d = jump_target;
                    end else if (branch_taken) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
                ST_TRAP: begin
                    // Control-flow inputs are ignored while the handler's first slot issues.
                    pc_d    = pc_plus4;
                    exc_d   = 1'b0;
                    state_d = ST_RUN;
                end
                default: begin
                    pc_d    = pc_plus4;
                    exc_d   = 1'b0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State registers with synchronous reset that overrides the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            epc_q        <= '0;
            exc_q        <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            exc_q        <= exc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign exc        = exc_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address/data width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0180: trap target address.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: 1 = advance; 0 = stall, all state held.
REQ-007 SHALL have port branch, input, 1: current instruction is a conditional branch.
REQ-008 SHALL have port branch_ne, input, 1: 0 = beq sense, 1 = bne sense.
REQ-009 SHALL have port zero, input, 1: ALU zero flag.
REQ-010 SHALL have port jump, input, 1: j/jal instruction.
REQ-011 SHALL have port jr, input, 1: jump-register instruction.
REQ-012 SHALL have port offset_sl2, input, WIDTH: sign-extended immediate, already shifted left by 2 (shift-left-2 output).
REQ-013 SHALL have port jump_index, input, 26: instr[25:0].
REQ-014 SHALL have port reg_target, input, WIDTH: rs value for jr.
REQ-015 SHALL have port pc, output, WIDTH: registered current PC.
REQ-016 SHALL have port pc_plus4, output, WIDTH: combinational pc+4 (for jal link).
REQ-017 SHALL have port branch_taken, output, 1: combinational, branch & (zero ^ branch_ne).
REQ-018 SHALL have port exc, output, 1: registered, high while state is TRAP.
REQ-019 SHALL have port epc, output, WIDTH: registered PC of the faulting jr.
REQ-020 SHALL have port retire_cnt, output, 32: registered count of enabled cycles.

Function
REQ-021 SHALL compute pc_plus4 = pc + 4, modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000).
REQ-022 SHALL compute branch target = pc_plus4 + offset_sl2, modulo 2^WIDTH; negative offsets wrap normally.
REQ-023 SHALL compute jump target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-024 SHALL select next PC in RUN with priority: jr > jump > branch_taken > pc_plus4.
REQ-025 SHALL treat a jr with reg_target[1:0] != 0 as misaligned: at the edge, pc <= EXC_VECTOR, epc <= pc, state <= TRAP.
REQ-026 SHALL NOT perform an alignment check on branch or jump targets; they are aligned by construction.
REQ-027 SHALL implement a two-state FSM, RUN and TRAP; TRAP lasts exactly one enabled cycle.
REQ-028 In TRAP, SHALL ignore branch/jump/jr, take pc <= pc_plus4, and return to RUN.
REQ-029 SHALL treat en=0 as an absolute stall: pc, state, epc, exc and retire_cnt all held, in both RUN and TRAP.
REQ-030 SHALL increment retire_cnt on every enabled edge (RUN or TRAP), wrapping 0xFFFF_FFFF -> 0.
REQ-031 SHALL let a misaligned jr that coincides with jump or branch_taken trap; jr priority governs.
REQ-032 SHALL keep branch_taken valid regardless of state or en; it is informational only and does not redirect PC in TRAP.
REQ-033 SHALL have single-cycle latency: control inputs sampled at edge N determine pc after edge N.

Reset
REQ-034 On rst=1 at an edge, SHALL set pc=RESET_PC, state=RUN, exc=0, epc=0, retire_cnt=0, irrespective of en.
REQ-035 SHALL let reset mid-TRAP abort the trap; TRAP SHALL NOT be re-entered without a new misaligned jr.
REQ-036 Combinational outputs after reset SHALL be pc_plus4=RESET_PC+4 and branch_taken per current inputs.

Verification
REQ-037 Reset, then 3 enabled idle cycles -> pc 0x0, 0x4, 0x8, 0xC; retire_cnt=3.
REQ-038 pc=0x40, branch=1, zero=1, offset_sl2=0xFFFF_FFF0 -> pc=0x34; same with branch_ne=1 -> pc=0x44.
REQ-039 pc=0x1000_0040, jump=1, jump_index=0x0000100 and branch_taken=1 in the same cycle -> pc=0x1000_0400 (jump wins).
REQ-040 pc=0x80, jr=1, reg_target=0x202 -> pc=0x180, epc=0x80, exc=1; the TRAP cycle has jump=1, jump_index=0x0000100, which is ignored -> pc=0x184, exc=0.
REQ-041 Stall during TRAP (en=0 for 2 cycles) -> pc=0x180 and exc=1 held, retire_cnt unchanged; rst asserted next -> pc=0x0, exc=0, epc=0.
REQ-042 pc=0xFFFF_FFFC, idle enabled cycle -> pc=0x0; retire_cnt forced to 0xFFFF_FFFF plus one enabled cycle -> 0.
